// File: rtl/bit_serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: operation codes, FSM state
// encoding and a small decode helper.
package bit_serial_alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Only ADD and SUB produce meaningful carry/overflow flags.
    function automatic logic is_arith(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/bit_serial_alu_alu1Bit.sv
// 1-bit ALU slice: logic ops, add, and subtract (b inverted, carry seeded by the caller).
module alu1Bit
    import bit_serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carryIn,
    input  logic [3:0] ALUOp,
    output logic       result,
    output logic       carryOut
);

    logic b_eff;

    always_comb begin
        b_eff    = (ALUOp == ALU_SUB) ? ~b : b;
        result   = 1'b0;
        carryOut = 1'b0;
        case (ALUOp)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_NOR:  result = ~a & ~b;
            ALU_NAND: result = ~a | ~b;
            ALU_ADD, ALU_SUB: begin
                result   = a ^ b_eff ^ carryIn;
                carryOut = (a & b_eff) | (carryIn & (a ^ b_eff));
            end
            default: begin
                result   = 1'b0;
                carryOut = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: operands are shifted LSB-first through a single 1-bit slice,
// one bit per cycle; results and flags are published when the FSM enters DONE.
module bit_serial_alu
    import bit_serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluOp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carryOut,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [3:0]         op_q;
    logic               carry_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               cout_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;

    logic               slice_res;
    logic               slice_cout;
    logic               last_bit;
    logic [WIDTH-1:0]   acc_d;

    alu1Bit u_slice (
        .a        (a_q[0]),
        .b        (b_q[0]),
        .carryIn  (carry_q),
        .ALUOp    (op_q),
        .result   (slice_res),
        .carryOut (slice_cout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    // New bits enter at the MSB so that after WIDTH shifts bit i sits at index i.
    assign acc_d    = {slice_res, acc_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= aluOp;
                        carry_q <= (aluOp == ALU_SUB);
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_q     <= {1'b0, a_q[WIDTH-1:1]};
                    b_q     <= {1'b0, b_q[WIDTH-1:1]};
                    acc_q   <= acc_d;
                    carry_q <= slice_cout;
                    if (last_bit) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= acc_d;
                        zero_q   <= (acc_d == '0);
                        cout_q   <= is_arith(op_q) ? slice_cout : 1'b0;
                        // carry_q still holds the carry into the MSB on the final bit.
                        ovf_q    <= is_arith(op_q) ? (carry_q ^ slice_cout) : 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign carryOut = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_bit_serial_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   aluOp;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         carryOut;
    logic         overflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] prev_res;
    logic         prev_z;
    logic         prev_c;
    logic         prev_v;

    bit_serial_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .aluOp    (aluOp),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .carryOut (carryOut),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {overflow, carryOut, zero, result} computed with plain arithmetic.
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [3:0] op);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0:  r = x & y;
            4'd1:  r = x | y;
            4'd2: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[W-1:0];
                c = s[W];
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            4'd6: begin
                s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
                r = s[W-1:0];
                c = s[W];
                v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            4'd12: r = ~(x | y);
            4'd13: r = ~(x & y);
            default: r = '0;
        endcase
        return {v, c, (r == '0), r};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge where done is high.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [3:0] top, input bit glitch);
        logic [W+2:0] e;
        int           cyc;
        bit           got;
        e     = model(ta, tb, top);
        start = 1'b1;
        a     = ta;
        b     = tb;
        aluOp = top;
        cyc   = 0;
        got   = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                a     = $urandom;
                b     = $urandom;
                aluOp = 4'($urandom);
                chk("busy_after_start", busy, 1);
            end
            if (glitch && cyc == 5) start = 1'b1;
            if (glitch && cyc == 6) start = 1'b0;
            if (cyc == 5) begin
                chk("result_held_in_run", result, prev_res);
                chk("zero_held_in_run", zero, prev_z);
                chk("cout_held_in_run", carryOut, prev_c);
                chk("ovf_held_in_run", overflow, prev_v);
            end
            if (done) got = 1'b1;
        end
        chk("done_latency", cyc, W + 1);
        chk("result", result, e[W-1:0]);
        chk("zero", zero, e[W]);
        chk("carryOut", carryOut, e[W+1]);
        chk("overflow", overflow, e[W+2]);
        chk("busy_at_done", busy, 0);
        prev_res = e[W-1:0];
        prev_z   = e[W];
        prev_c   = e[W+1];
        prev_v   = e[W+2];
    endtask

    initial begin
        logic [3:0] op;
        int         seen;
        reset    = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        aluOp    = '0;
        prev_res = '0;
        prev_z   = 1'b0;
        prev_c   = 1'b0;
        prev_v   = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {zero, carryOut, overflow}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Directed corner cases
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 1'b0);
        chk("add_ovf_result_const", result, 32'h8000_0000);
        chk("add_ovf_flag_const", {zero, carryOut, overflow}, 3'b001);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("result_held_idle", result, 32'h8000_0000);

        do_op(32'd5, 32'd5, 4'b0110, 1'b0);
        chk("sub_eq_flags_const", {zero, carryOut, overflow}, 3'b110);
        do_op(32'h0F0F_0F0F, 32'h00FF_00FF, 4'b1100, 1'b0);
        chk("nor_const", result, 32'hF000_F000);
        // start during DONE: accepted back-to-back
        do_op(32'hFFFF_0000, 32'hFF00_FF00, 4'b1101, 1'b0);
        chk("nand_const", result, 32'h00FF_FFFF);
        do_op($urandom, $urandom, 4'b0111, 1'b0);
        chk("invalid_zero_const", {result, zero}, {32'h0, 1'b1});
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 4'b0010, 1'b1);
        do_op(32'h0000_0003, 32'h0000_0005, 4'b0110, 1'b0);
        @(negedge clk);

        // Reset in the middle of an ADD
        start = 1'b1;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0123_4567;
        aluOp = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_flags", {zero, carryOut, overflow}, 0);
        reset = 1'b0;
        seen  = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("no_done_after_reset", seen, 0);
        prev_res = '0;
        prev_z   = 1'b0;
        prev_c   = 1'b0;
        prev_v   = 1'b0;

        // Randomized operations
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 7))
                0:       op = 4'b0000;
                1:       op = 4'b0001;
                2:       op = 4'b0010;
                3:       op = 4'b0110;
                4:       op = 4'b1100;
                5:       op = 4'b1101;
                6:       op = 4'($urandom);
                default: op = $urandom_range(0, 1) ? 4'b0010 : 4'b0110;
            endcase
            do_op(pick(), pick(), op, ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu.md
BIT_SERIAL_ALU -- requirements
Module: bit_serial_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only when accepted (see REQ-013).
REQ-005 a  input  WIDTH  operand A, captured on accepted start.
REQ-006 b  input  WIDTH  operand B, captured on accepted start.
REQ-007 aluOp  input  4  operation code, captured on accepted start.
REQ-008 busy  output  1  high while an operation is being processed.
REQ-009 done  output  1  one-cycle pulse marking results valid.
REQ-010 result  output  WIDTH  operation result, held until next accepted start or reset.
REQ-011 zero, carryOut, overflow  output  1 each  status flags, held with result.

Function
REQ-012 The block SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 start SHALL be accepted in IDLE or DONE; IDLE/DONE -> RUN, capturing a, b, aluOp; start in RUN SHALL be ignored.
REQ-014 RUN SHALL process one bit per cycle, LSB first, bit index counter 0..WIDTH-1, through a single 1-bit ALU slice.
REQ-015 After processing bit WIDTH-1, the FSM SHALL enter DONE; DONE with no start -> IDLE.
REQ-016 busy SHALL equal (state == RUN); done SHALL equal (state == DONE).
REQ-017 Latency: start accepted at edge N -> done high in the cycle after edge N+WIDTH (start at cycle 0, done at cycle WIDTH+1).
REQ-018 Supported codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR (~a & ~b), 1101 NAND (~a | ~b); any other code SHALL yield all-zero result bits.
REQ-019 Carry register SHALL initialise to 1 for 0110 and 0 for all other codes; each RUN cycle it SHALL load the slice carry-out.
REQ-020 result bits SHALL be shifted in MSB-side; after the last bit, result[i] equals the slice output for bit i.
REQ-021 zero SHALL be 1 iff final result == 0, for every code including invalid ones.
REQ-022 carryOut SHALL be the carry out of bit WIDTH-1 for ADD/SUB, else 0.
REQ-023 overflow SHALL be carry-into-MSB XOR carry-out-of-MSB for ADD/SUB, else 0.
REQ-024 result, zero, carryOut, overflow SHALL update only when entering DONE; during RUN they hold the previous operation's values.

Reset
REQ-025 On reset (including mid-RUN) the block SHALL enter IDLE, clear bit counter, carry, operand registers, and drive busy=0, done=0, result=0, zero=0, carryOut=0, overflow=0 on the following cycle.
REQ-026 reset SHALL take priority over start in the same cycle.

Structure
REQ-027 A shared package SHALL hold the ALUOp code constants (AND, OR, ADD, SUB, NOR, NAND) and the FSM state encoding.
REQ-028 One sub-module SHALL be instantiated: alu1Bit, the team's 1-bit ALU slice (a, b, carryIn, ALUOp -> result, carryOut).
REQ-029 Operand shift registers, carry flop, bit counter, and FSM SHALL reside in bit_serial_alu.

Verification
REQ-030 ADD a=0x7FFFFFFF, b=0x00000001 -> result 0x80000000, overflow=1, carryOut=0, zero=0, done at cycle 33.
REQ-031 SUB a=5, b=5 -> result 0x00000000, zero=1, carryOut=1, overflow=0.
REQ-032 NOR a=0x0F0F0F0F, b=0x00FF00FF -> result 0xF000F000; NAND a=0xFFFF0000, b=0xFF00FF00 -> 0x00FFFFFF; flags carryOut=overflow=0.
REQ-033 Invalid aluOp=0111, any operands -> result 0, zero=1, done still at cycle 33.
REQ-034 start pulsed at cycle 5 of a RUN with new operands -> ignored; original result returned; start in the DONE cycle -> accepted, busy next cycle.
REQ-035 reset asserted at bit 10 of an ADD -> next cycle busy=0, done=0, result=0; no done pulse follows.
